// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a busy scoreboard.
//   NUM_READ combinational read ports (data + busy), two synchronous write
//   lanes (lane 1 wins on a same-address collision), and a reservation port
//   that marks a register busy until a write lane retires into it.
//   R0 is hardwired to zero and is never busy.
// Ports:
//   clk, reset (async, active-high)
//   rd_addr/rd_data/rd_busy   : packed per-port read address, data, busy
//   we0/waddr0/wdata0         : write lane 0
//   we1/waddr1/wdata1         : write lane 1
//   rsv_en/rsv_addr, rsv_ok   : reservation request, combinational accept
//   busy_cnt                  : registered number of busy registers
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
//   (and the resulting busy state) onto the read ports.
module regfile_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_READ-1:0]              rd_busy,
  input  logic                             we0,
  input  logic [ADDR_WIDTH-1:0]            waddr0,
  input  logic [DATA_WIDTH-1:0]            wdata0,
  input  logic                             we1,
  input  logic [ADDR_WIDTH-1:0]            waddr1,
  input  logic [DATA_WIDTH-1:0]            wdata1,
  input  logic                             rsv_en,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr,
  output logic                             rsv_ok,
  output logic [ADDR_WIDTH:0]              busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [CW-1:0]         busy_cnt_q, busy_cnt_d;

  logic wr0_act, wr1_act, clr0, clr1;

  // Writes to R0 are dropped at the source so R0 never changes.
  assign wr0_act = we0 && (waddr0 != '0);
  assign wr1_act = we1 && (waddr1 != '0);

  // Only busy targets count as cleared; a collision clears one register once.
  assign clr0 = wr0_act && busy_q[waddr0];
  assign clr1 = wr1_act && busy_q[waddr1] && !(wr0_act && (waddr0 == waddr1));

  // Reservation is judged on pre-edge busy, so it never overlaps a clear.
  assign rsv_ok = rsv_en && (rsv_addr != '0) && !busy_q[rsv_addr];

  // Next state: lane 0, then lane 1 (wins collisions), then the reservation
  // set, which overrides a same-cycle write clear.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q + CW'(rsv_ok) - CW'(clr0) - CW'(clr1);
    if (wr0_act) begin
      regs_d[waddr0] = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (wr1_act) begin
      regs_d[waddr1] = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1;
    assign hit0 = wr0_act && (waddr0 == ra);
    assign hit1 = wr1_act && (waddr1 == ra);
    // A forwarded register is about to be clean unless reserved this cycle.
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
      hit1 ? wdata1 : (hit0 ? wdata0 : ((ra == '0) ? '0 : regs_q[ra]));
    assign rd_busy[k] = (hit0 || hit1) ? (rsv_ok && (rsv_addr == ra))
                                       : ((ra != '0) && busy_q[ra]);
`else
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : regs_q[ra];
    assign rd_busy[k] = (ra != '0) && busy_q[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              we0 = 1'b0, we1 = 1'b0, rsv_en = 1'b0;
  logic [AW-1:0]     waddr0 = '0, waddr1 = '0, rsv_addr = '0;
  logic [DW-1:0]     wdata0 = '0, wdata1 = '0;
  logic              rsv_ok;
  logic [AW:0]       busy_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 data, 1 busy, 2 busy_cnt, 3 rsv_ok
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  // Independent reference state for the random phase.
  logic [DW-1:0] mr [32];
  logic          mb [32];

  regfile_mp dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic push(input string n, input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = kind; e.port = port; e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      0: return rd_data[port*DW +: DW];
      1: return {31'b0, rd_busy[port]};
      2: return {26'b0, busy_cnt};
      default: return {31'b0, rsv_ok};
    endcase
  endfunction

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    idle();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick();
    idle();
    set_rd(0, 5'd5); set_rd(1, 5'd6); set_rd(2, 5'd6);
    #1;
    push("pre_reset_r5", 0, 0, 32'hDEADBEEF);
    push("pre_reset_busy_r6", 1, 1, 32'd1);
    push("pre_reset_cnt", 2, 0, 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    // Reset while a write is pending on the inputs must discard it.
    we0 = 1'b1; wdata0 = 32'h12345678;
    reset = 1'b1;
    tick();
    push("reset_r5", 0, 0, 32'd0);
    push("reset_cnt", 2, 0, 32'd0);
    push("reset_busy0", 1, 0, 32'd0);
    push("reset_busy1", 1, 1, 32'd0);
    push("reset_busy2", 1, 2, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    idle();
    reset = 1'b0;
    tick();
    push("post_reset_r5", 0, 0, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_r0();
    exp_t e; logic [31:0] got;
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    tick();
    idle();
    set_rd(0, 5'd0);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    push("r0_data", 0, 0, 32'd0);
    push("r0_rsv_ok", 3, 0, 32'd0);
    push("r0_busy", 1, 0, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    tick();
    idle();
    push("r0_cnt", 2, 0, 32'd0);
    push("r0_busy_after", 1, 0, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_collision();
    exp_t e; logic [31:0] got;
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    tick();
    idle();
    set_rd(0, 5'd7);
    #1;
    push("collision_r7", 0, 0, 32'h22);
    push("collision_cnt", 2, 0, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_dual_write();
    exp_t e; logic [31:0] got;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA;
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hB;
    tick();
    idle();
    set_rd(0, 5'd3); set_rd(1, 5'd4);
    #1;
    push("dual_r3", 0, 0, 32'hA);
    push("dual_r4", 0, 1, 32'hB);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e; logic [31:0] got;
    set_rd(2, 5'd9);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    push("rsv1_ok", 3, 0, 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    tick();
    push("rsv2_ok", 3, 0, 32'd0);
    push("rsv1_cnt", 2, 0, 32'd1);
    push("rsv1_busy", 1, 2, 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    tick();
    idle();
    push("rsv2_cnt", 2, 0, 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h55;
    tick();
    idle();
    push("retire_busy", 1, 2, 32'd0);
    push("retire_cnt", 2, 0, 32'd0);
    push("retire_data", 0, 2, 32'h55);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_rsv_write();
    exp_t e; logic [31:0] got;
    set_rd(0, 5'd12);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h77;
    #1;
    push("rw_rsv_ok", 3, 0, 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    tick();
    idle();
    push("rw_data", 0, 0, 32'h77);
    push("rw_busy", 1, 0, 32'd1);
    push("rw_cnt", 2, 0, 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [31:0] got;
    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h1111;
    tick();
    idle();
    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h1234;
    set_rd(2, 5'd2);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("bypass_same_cycle", 0, 2, 32'h1234);
`else
    push("bypass_same_cycle", 0, 2, 32'h1111);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
    tick();
    idle();
    push("bypass_next_cycle", 0, 2, 32'h1234);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    end
  endtask

  // Random back-to-back traffic on a narrow address range against the model.
  task automatic test_back_to_back();
    exp_t e; logic [31:0] got;
    logic rok;
    logic [AW-1:0] a;
    logic [31:0] xd;
    logic xb;
    int cnt;
    idle();
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 32; i++) begin mr[i] = '0; mb[i] = 1'b0; end
    tick();
    for (int n = 0; n < 300; n++) begin
      we0 = ($urandom_range(0, 9) < 4); waddr0 = AW'($urandom_range(0, 7)); wdata0 = $urandom;
      we1 = ($urandom_range(0, 9) < 4); waddr1 = AW'($urandom_range(0, 7)); wdata1 = $urandom;
      rsv_en = ($urandom_range(0, 9) < 5); rsv_addr = AW'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++) set_rd(k, AW'($urandom_range(0, 7)));
      #1;
      rok = rsv_en && (rsv_addr != 0) && !mb[rsv_addr];
      push("rnd_rsv_ok", 3, 0, {31'b0, rok});
      for (int k = 0; k < NR; k++) begin
        a = rd_addr[k*AW +: AW];
        xd = mr[a]; xb = mb[a];
`ifdef REGFILE_BYPASS_EN
        if (we1 && waddr1 != 0 && waddr1 == a) begin xd = wdata1; xb = rok && rsv_addr == a; end
        else if (we0 && waddr0 != 0 && waddr0 == a) begin xd = wdata0; xb = rok && rsv_addr == a; end
`endif
        push("rnd_rd_data", 0, k, xd);
        push("rnd_rd_busy", 1, k, {31'b0, xb});
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h (iter %0d)", e.name, got, e.val, n); end
      end
      if (we0 && waddr0 != 0) begin mr[waddr0] = wdata0; mb[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin mr[waddr1] = wdata1; mb[waddr1] = 1'b0; end
      if (rok) mb[rsv_addr] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += int'(mb[i]);
      tick();
      push("rnd_busy_cnt", 2, 0, 32'(cnt));
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.kind, e.port); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h (iter %0d)", e.name, got, e.val, n); end
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_r0();
    test_collision();
    test_dual_write();
    test_scoreboard();
    test_rsv_write();
    test_bypass();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, two-read CPU register file.
- Provides NUM_READ asynchronous read ports, two synchronous write ports and a per-register busy scoreboard for pending writes.
- Sits between decode (reads, reservations) and writeback (two retire lanes).
- R0 is hardwired to zero and is never busy.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 3, number of read ports (1..8).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*DATA_WIDTH  read data, port k in slice [k*DATA_WIDTH +: DATA_WIDTH].
- rd_busy  out  NUM_READ  port k busy bit of the addressed register.
- we0  in  1  write enable, lane 0.
- waddr0  in  ADDR_WIDTH  write address, lane 0.
- wdata0  in  DATA_WIDTH  write data, lane 0.
- we1  in  1  write enable, lane 1.
- waddr1  in  ADDR_WIDTH  write address, lane 1.
- wdata1  in  DATA_WIDTH  write data, lane 1.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- rsv_ok  out  1  combinational: reservation will be accepted this cycle.
- busy_cnt  out  ADDR_WIDTH+1  registered count of busy registers.

Behaviour:
- Reset (async, high):
  - All registers = 0 and all busy bits = 0.
  - busy_cnt = 0.
  - rd_data and rd_busy follow from the cleared state, so they read 0.
  - Reset asserted mid-operation discards any in-flight write or reservation that cycle.
- Reads are combinational.
  - rd_data[k] = reg[rd_addr[k]].
  - rd_busy[k] = busy[rd_addr[k]].
  - Address 0 always returns data 0 and busy 0.
- Writes:
  - A lane writes on the rising edge when its we is high and its waddr != 0.
  - Any write with address 0 is ignored.
  - A write clears the busy bit of its target.
- Write collision (we0 and we1 both high, same nonzero address): lane 1 data is stored; busy is cleared once.
- Reservation:
  - rsv_ok = rsv_en & (rsv_addr != 0) & ~busy[rsv_addr].
  - When rsv_ok is high, busy[rsv_addr] is set on the edge.
  - A reservation to an already-busy register is refused: rsv_ok = 0, no state change; requester must stall and retry.
- Same-cycle reserve and write to the same register:
  - The write updates the data.
  - The write clears busy, but the reservation sets it; the set wins, so the register ends busy.
  - rsv_ok is evaluated on pre-edge busy; if the register was busy, rsv_ok = 0 and the write simply clears it.
- busy_cnt:
  - Next value = current + (reservation accepted) - (number of distinct busy registers cleared this edge, excluding any re-set by the same-cycle reservation).
  - Range 0..2**ADDR_WIDTH-1; never wraps. A write to a non-busy register does not decrement.
- Read latency:
  - Without bypass, a read in the same cycle as a write returns the old value.
  - The new value is visible the cycle after the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If rd_addr[k] matches an active, nonzero write lane this cycle, rd_data[k] returns that lane's wdata (lane 1 over lane 0).
  - rd_busy[k] = 0 unless a same-cycle accepted reservation targets the same address.
- Not defined: reads return stored contents only (old value in the write cycle); rd_busy reflects pre-edge busy bits.

Test Plan:
- Reset:
  - Stimulus: write 0xDEADBEEF to R5, assert reset for 1 cycle.
  - Required: rd_data for R5 = 0; busy_cnt = 0; all rd_busy = 0.
- R0 protection:
  - Stimulus: we0 with waddr0 = 0, wdata0 = 0xFFFFFFFF; then rsv_en with rsv_addr = 0.
  - Required: R0 reads 0; rsv_ok = 0; busy_cnt stays 0.
- Dual write collision:
  - Stimulus: we0 = we1 = 1, both addresses = 7, wdata0 = 0x11, wdata1 = 0x22.
  - Required: next cycle R7 = 0x22.
- Different-address dual write:
  - Stimulus: R3 <- 0xA, R4 <- 0xB in the same cycle.
  - Required: both readable next cycle on ports 0 and 1.
- Scoreboard:
  - Stimulus: reserve R9, then reserve R9 again.
  - Required: first gives rsv_ok = 1 and busy_cnt = 1; second gives rsv_ok = 0.
  - Stimulus: write R9 = 0x55.
  - Required: next cycle rd_busy for R9 = 0, busy_cnt = 0, data = 0x55.
- Simultaneous reserve and write on idle R12:
  - Stimulus: reserve R12 and write R12 = 0x77 in the same cycle.
  - Required: R12 = 0x77, busy = 1, busy_cnt = 1.
- Bypass build:
  - Stimulus: write R2 = 0x1234 while port 2 reads R2.
  - Required with REGFILE_BYPASS_EN: same cycle rd_data = 0x1234.
  - Required without it: old value that cycle, 0x1234 the next cycle.
